// File: rtl/ltl_monitor_engine.sv
`default_nettype none
// ============================================================================
// Module      : ltl_monitor_engine
// Description : Homogeneous automaton (STE) engine for runtime monitoring;
//               one symbol per run cycle, with report counters and capture.
// Revision    : 1.0 - initial release
// ============================================================================
module ltl_monitor_engine #(
    parameter int N_STE = 16,
    parameter int SYM_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [SYM_W-1:0]         symbols,
    input  logic                     restart,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_sel,
    input  logic [((SYM_W > $clog2(N_STE)) ? SYM_W : $clog2(N_STE))-1:0] cfg_addr,
    input  logic [N_STE-1:0]         cfg_wdata,
    output logic                     cfg_err,
    output logic [N_STE-1:0]         active_state,
    output logic [N_STE-1:0]         report_vec,
    output logic                     report_any,
    output logic [N_STE-1:0]         report_sticky,
    output logic [CNT_W-1:0]         report_count,
    output logic [CNT_W-1:0]         symbol_count,
    output logic [CNT_W-1:0]         first_report_pos,
    output logic                     first_report_valid
);

    localparam int c_NSYM   = 1 << SYM_W;
    localparam int c_STE_AW = $clog2(N_STE);
    localparam int c_CFG_AW = (SYM_W > c_STE_AW) ? SYM_W : c_STE_AW;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [N_STE-1:0] r_match [c_NSYM];
    logic [N_STE-1:0] r_edge  [N_STE];
    logic [N_STE-1:0] r_start_sod;
    logic [N_STE-1:0] r_start_all;
    logic [N_STE-1:0] r_report_mask;
    logic [N_STE-1:0] r_active;
    logic [N_STE-1:0] r_sticky;
    logic             r_sod_armed;
    logic             r_cfg_err;
    logic [CNT_W-1:0] r_report_count;
    logic [CNT_W-1:0] r_symbol_count;
    logic [CNT_W-1:0] r_first_pos;
    logic             r_first_valid;

    logic [31:0]      w_addr32;
    logic             w_target_ok;
    logic             w_cfg_accept;
    logic [N_STE-1:0] w_enable;
    logic [N_STE-1:0] w_next_active;
    logic             w_next_report;

    assign w_addr32     = 32'(cfg_addr);
    assign w_cfg_accept = cfg_we & ~run & w_target_ok;

    always_comb begin
        w_target_ok = 1'b0;
        case (cfg_sel)
            3'd0:                w_target_ok = (w_addr32 < 32'(c_NSYM));
            3'd1:                w_target_ok = (w_addr32 < 32'(N_STE));
            3'd2, 3'd3, 3'd4:    w_target_ok = 1'b1;
            default:             w_target_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_enable = '0;
        for (int i = 0; i < N_STE; i++) begin
            w_enable[i] = (r_sod_armed & r_start_sod[i]) | r_start_all[i]
                        | (|(r_edge[i] & r_active));
        end
    end

    assign w_next_active = w_enable & r_match[symbols];
    assign w_next_report = |(w_next_active & r_report_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < c_NSYM; k++) r_match[k] <= '0;
            for (int k = 0; k < N_STE; k++)  r_edge[k]  <= '0;
            r_start_sod   <= '0;
            r_start_all   <= '0;
            r_report_mask <= '0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we & (run | ~w_target_ok);
            if (w_cfg_accept) begin
                case (cfg_sel)
                    3'd0:    r_match[cfg_addr[SYM_W-1:0]]   <= cfg_wdata;
                    3'd1:    r_edge[cfg_addr[c_STE_AW-1:0]] <= cfg_wdata;
                    3'd2:    r_start_sod   <= cfg_wdata;
                    3'd3:    r_start_all   <= cfg_wdata;
                    3'd4:    r_report_mask <= cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Report count and first position are updated on the consuming edge, so they
    // change together with the report_any that the consumed symbol produces.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active       <= '0;
            r_sticky       <= '0;
            r_sod_armed    <= 1'b1;
            r_report_count <= '0;
            r_symbol_count <= '0;
            r_first_pos    <= '0;
            r_first_valid  <= 1'b0;
        end else begin
            r_sticky <= r_sticky | report_vec;
            if (restart) begin
                r_active    <= '0;
                r_sod_armed <= 1'b1;
            end else if (run) begin
                r_active    <= w_next_active;
                r_sod_armed <= 1'b0;
                if (r_symbol_count != c_CNT_MAX) r_symbol_count <= r_symbol_count + 1'b1;
                if (w_next_report) begin
                    if (r_report_count != c_CNT_MAX) r_report_count <= r_report_count + 1'b1;
                    if (!r_first_valid) begin
                        r_first_pos   <= r_symbol_count;
                        r_first_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign cfg_err            = r_cfg_err;
    assign active_state       = r_active;
    assign report_vec         = r_active & r_report_mask;
    assign report_any         = |report_vec;
    assign report_sticky      = r_sticky;
    assign report_count       = r_report_count;
    assign symbol_count       = r_symbol_count;
    assign first_report_pos   = r_first_pos;
    assign first_report_valid = r_first_valid;

endmodule
`default_nettype wire

// File: tb/tb_ltl_monitor_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltl_monitor_engine
// Description : Directed self-checking bench for ltl_monitor_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltl_monitor_engine;

    localparam int N_STE = 4;
    localparam int SYM_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic [SYM_W-1:0] symbols = '0;
    logic             restart = 1'b0;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_sel = '0;
    logic [7:0]       cfg_addr = '0;
    logic [N_STE-1:0] cfg_wdata = '0;
    logic             cfg_err;
    logic [N_STE-1:0] active_state;
    logic [N_STE-1:0] report_vec;
    logic             report_any;
    logic [N_STE-1:0] report_sticky;
    logic [CNT_W-1:0] report_count;
    logic [CNT_W-1:0] symbol_count;
    logic [CNT_W-1:0] first_report_pos;
    logic             first_report_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ltl_monitor_engine #(.N_STE(N_STE), .SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .symbols(symbols), .restart(restart),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .active_state(active_state), .report_vec(report_vec),
        .report_any(report_any), .report_sticky(report_sticky), .report_count(report_count),
        .symbol_count(symbol_count), .first_report_pos(first_report_pos),
        .first_report_valid(first_report_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [7:0] addr, input logic [N_STE-1:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic feed(input logic [SYM_W-1:0] sym);
        run = 1'b1; symbols = sym;
        tick();
        run = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic config_chain();
        cfg_write(3'd0, 8'h41, 4'b0001);
        cfg_write(3'd0, 8'h42, 4'b0010);
        cfg_write(3'd1, 8'd1,  4'b0001);
        cfg_write(3'd2, 8'd0,  4'b0001);
        cfg_write(3'd4, 8'd0,  4'b0010);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++; if (active_state !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", active_state); end
        checks++; if (report_any !== 1'b0) begin errors++; $display("FAIL reset_report_any: got %b expected 0", report_any); end
        checks++; if (symbol_count !== 4'd0 || report_count !== 4'd0) begin errors++; $display("FAIL reset_counts: got sc=%0d rc=%0d expected 0/0", symbol_count, report_count); end
        checks++; if (first_report_valid !== 1'b0 || cfg_err !== 1'b0 || report_sticky !== 4'b0000) begin errors++; $display("FAIL reset_misc: got frv=%b err=%b sticky=%b expected 0/0/0000", first_report_valid, cfg_err, report_sticky); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_chain_report();
        do_reset();
        config_chain();
        feed(8'h41);
        checks++; if (active_state !== 4'b0001 || report_any !== 1'b0) begin errors++; $display("FAIL chain_first: got act=%b any=%b expected 0001/0", active_state, report_any); end
        feed(8'h42);
        checks++; if (report_vec !== 4'b0010 || report_any !== 1'b1) begin errors++; $display("FAIL chain_report: got vec=%b any=%b expected 0010/1", report_vec, report_any); end
        checks++; if (first_report_pos !== 4'd1 || first_report_valid !== 1'b1) begin errors++; $display("FAIL chain_first_pos: got pos=%0d v=%b expected 1/1", first_report_pos, first_report_valid); end
        checks++; if (report_count !== 4'd1 || symbol_count !== 4'd2) begin errors++; $display("FAIL chain_counts: got rc=%0d sc=%0d expected 1/2", report_count, symbol_count); end
        tick();
        checks++; if (report_sticky !== 4'b0010 || active_state !== 4'b0010) begin errors++; $display("FAIL chain_sticky_hold: got sticky=%b act=%b expected 0010/0010", report_sticky, active_state); end
    endtask

    task automatic test_sod_restart();
        do_reset();
        config_chain();
        feed(8'h00);
        feed(8'h41);
        feed(8'h42);
        checks++; if (active_state !== 4'b0000 || report_count !== 4'd0 || first_report_valid !== 1'b0) begin errors++; $display("FAIL sod_disarmed: got act=%b rc=%0d frv=%b expected 0000/0/0", active_state, report_count, first_report_valid); end
        feed(8'h41);
        checks++; if (active_state !== 4'b0000) begin errors++; $display("FAIL sod_still_disarmed: got %b expected 0000", active_state); end
        restart = 1'b1; run = 1'b1; symbols = 8'h41;
        tick();
        restart = 1'b0; run = 1'b0;
        checks++; if (active_state !== 4'b0000 || symbol_count !== 4'd4) begin errors++; $display("FAIL restart_wins: got act=%b sc=%0d expected 0000/4", active_state, symbol_count); end
        feed(8'h41);
        feed(8'h42);
        checks++; if (report_vec !== 4'b0010 || first_report_pos !== 4'd5 || symbol_count !== 4'd6) begin errors++; $display("FAIL restart_report: got vec=%b pos=%0d sc=%0d expected 0010/5/6", report_vec, first_report_pos, symbol_count); end
    endtask

    task automatic test_start_all_gaps();
        do_reset();
        for (int s = 0; s < 32; s++) cfg_write(3'd0, 8'(s), 4'b0001);
        cfg_write(3'd1, 8'd0, 4'b0001);
        cfg_write(3'd3, 8'd0, 4'b0001);
        cfg_write(3'd4, 8'd0, 4'b0001);
        feed(8'h05); tick();
        feed(8'h05); tick(); tick();
        checks++; if (active_state !== 4'b0001 || symbol_count !== 4'd2 || report_count !== 4'd2) begin errors++; $display("FAIL gap_hold: got act=%b sc=%0d rc=%0d expected 0001/2/2", active_state, symbol_count, report_count); end
        feed(8'h05);
        checks++; if (report_count !== 4'd3 || symbol_count !== 4'd3) begin errors++; $display("FAIL gap_counts: got rc=%0d sc=%0d expected 3/3", report_count, symbol_count); end
        feed(8'h20);
        checks++; if (active_state !== 4'b0000 || report_count !== 4'd3 || symbol_count !== 4'd4) begin errors++; $display("FAIL range_edge: got act=%b rc=%0d sc=%0d expected 0000/3/4", active_state, report_count, symbol_count); end
    endtask

    task automatic test_cfg_errors();
        cfg_we = 1'b1; cfg_sel = 3'd0; cfg_addr = 8'h05; cfg_wdata = 4'b0000;
        run = 1'b1; symbols = 8'h05;
        tick();
        cfg_we = 1'b0; run = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_run_pulse: got %b expected 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_run_one_cycle: got %b expected 0", cfg_err); end
        feed(8'h20);
        feed(8'h05);
        checks++; if (active_state !== 4'b0001) begin errors++; $display("FAIL err_table_kept: got %b expected 0001", active_state); end
        cfg_write(3'd6, 8'd0, 4'b1111);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_bad_sel: got %b expected 1", cfg_err); end
        cfg_write(3'd1, 8'd4, 4'b1111);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_bad_row: got %b expected 1", cfg_err); end
        cfg_write(3'd4, 8'd0, 4'b0001);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_good_write: got %b expected 0", cfg_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        cfg_write(3'd0, 8'h07, 4'b0001);
        cfg_write(3'd3, 8'd0, 4'b0001);
        cfg_write(3'd4, 8'd0, 4'b0001);
        for (int n = 0; n < 20; n++) feed(8'h07);
        checks++; if (report_count !== 4'd15 || symbol_count !== 4'd15) begin errors++; $display("FAIL saturate: got rc=%0d sc=%0d expected 15/15", report_count, symbol_count); end
        checks++; if (first_report_pos !== 4'd0 || first_report_valid !== 1'b1) begin errors++; $display("FAIL sat_first_pos: got pos=%0d v=%b expected 0/1", first_report_pos, first_report_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        config_chain();
        feed(8'h41);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (active_state !== 4'b0000 || symbol_count !== 4'd0 || report_any !== 1'b0) begin errors++; $display("FAIL async_reset: got act=%b sc=%0d any=%b expected 0000/0/0", active_state, symbol_count, report_any); end
        #1;
        reset = 1'b0;
        checks++; if (active_state !== 4'b0000) begin errors++; $display("FAIL async_reset_held: got %b expected 0000", active_state); end
        config_chain();
        feed(8'h41);
        checks++; if (active_state !== 4'b0001 || symbol_count !== 4'd1) begin errors++; $display("FAIL post_reset_sod: got act=%b sc=%0d expected 0001/1", active_state, symbol_count); end
    endtask

    initial begin
        test_reset();
        test_chain_report();
        test_sod_restart();
        test_start_all_gaps();
        test_cfg_errors();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
